// File: rtl/bicubic_line_window_pkg.sv
// Shared constants, window type and ring-slot arithmetic for the bicubic line window.
package bicubic_line_window_pkg;

  localparam int unsigned DW    = 24;
  localparam int unsigned PIX_W = 24;
  localparam int unsigned TAPS  = 4;
  localparam int unsigned NSLOT = 5;
  localparam int unsigned ROW_W = 12;
  localparam int unsigned COL_W = 12;

  typedef logic [TAPS*DW-1:0] window_t;
  typedef logic [2:0]         slot_t;

  // (s + k) mod NSLOT for s < NSLOT, k < NSLOT; a compare-subtract, no divider
  function automatic slot_t slot_add(input slot_t s, input logic [2:0] k);
    logic [3:0] sum;
    sum = 4'(s) + 4'(k);
    if (sum >= 4'(NSLOT)) sum = sum - 4'(NSLOT);
    return slot_t'(sum);
  endfunction

endpackage

// File: rtl/bicubic_line_window_line_bank_ram.sv
// Simple dual-port line bank: one write port, one registered read port.
module line_bank_ram #(
  parameter int unsigned DW    = 24,
  parameter int unsigned DEPTH = 480,
  parameter int unsigned AW    = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write when enabled; read data is always registered one cycle after the address
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/bicubic_line_window.sv
// Five-slot line ring serving 4x4 pixel windows to the bicubic resize datapath.
module bicubic_line_window
  import bicubic_line_window_pkg::*;
#(
  parameter int unsigned MAX_WIDTH = 1920
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [11:0]   img_width,
  input  logic [10:0]   img_height,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          wr_ready,
  input  logic          rd_en,
  input  logic [10:0]   rd_addr,
  input  logic          rd_finish,
  output logic          rd_ready,
  output logic          valid_o,
  output window_t       prev_line_data_o,
  output window_t       cur_line_data_o,
  output window_t       next_line1_data_o,
  output window_t       next_line2_data_o
);

  localparam int unsigned DEPTH = (MAX_WIDTH + TAPS - 1) / TAPS;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [COL_W-1:0] wr_col;
  logic [ROW_W-1:0] wr_line;
  logic [ROW_W-1:0] rd_line;
  slot_t            wr_slot;
  slot_t            rd_slot;
  logic             init_done;

  logic [ROW_W-1:0] height;
  logic [ROW_W-1:0] last_row;
  logic [ROW_W:0]   need_row;
  logic             accept;
  logic             line_done;
  logic             frame_end;

  assign height    = {1'b0, img_height};
  assign last_row  = height - 12'd1;
  assign accept    = valid_i & wr_ready;
  assign line_done = accept && (wr_col == (img_width - 12'd1));
  assign frame_end = rd_finish && (rd_line == last_row);

  // Writer may run at most three rows ahead so row n-1 survives until row n retires
  assign wr_ready = init_done
                    && (13'(wr_line) <= (13'(rd_line) + 13'd3))
                    && (wr_line < height);

  // Rows n-1..n+2 that exist in the frame are all stored
  assign need_row = ((13'(rd_line) + 13'd2) < 13'(last_row)) ? (13'(rd_line) + 13'd2)
                                                              : 13'(last_row);
  assign rd_ready = 13'(wr_line) > need_row;

  // Write/read position counters with ring-slot shadows; frame end clears everything
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_col    <= '0;
      wr_line   <= '0;
      rd_line   <= '0;
      wr_slot   <= '0;
      rd_slot   <= '0;
      init_done <= 1'b0;
    end else begin
      init_done <= 1'b1;
      if (frame_end) begin
        wr_col  <= '0;
        wr_line <= '0;
        rd_line <= '0;
        wr_slot <= '0;
        rd_slot <= '0;
      end else begin
        if (accept) begin
          if (line_done) begin
            wr_col  <= '0;
            wr_line <= wr_line + 12'd1;
            wr_slot <= slot_add(wr_slot, 3'd1);
          end else begin
            wr_col <= wr_col + 12'd1;
          end
        end
        if (rd_finish) begin
          rd_line <= rd_line + 12'd1;
          rd_slot <= slot_add(rd_slot, 3'd1);
        end
      end
    end
  end

  // Stage 0: lane columns, column validity and per-bank read addresses
  logic signed [12:0] base;
  logic signed [12:0] lane_col [TAPS];
  logic [TAPS-1:0]    col_ok_d;
  logic [1:0]         rot_d;
  logic [AW-1:0]      bank_raddr [TAPS];

  always_comb begin
    base     = $signed({2'b00, rd_addr}) - 13'sd1;
    rot_d    = base[1:0];
    col_ok_d = '0;
    for (int k = 0; k < TAPS; k++) begin
      lane_col[k] = base + 13'(k);
      col_ok_d[k] = (lane_col[k] >= 13'sd0) && (lane_col[k] < $signed({1'b0, img_width}));
    end
    for (int b = 0; b < TAPS; b++) begin
      bank_raddr[b] = col_ok_d[2'(2'(b) - rot_d)] ? lane_col[2'(2'(b) - rot_d)][AW+1:2] : '0;
    end
  end

  // Stage 0: row validity and slot of each output row, taken from pre-finish rd_line
  logic [TAPS-1:0] row_ok_d;
  slot_t           row_slot_d [TAPS];

  always_comb begin
    row_ok_d[0]   = (rd_line != 12'd0);
    row_ok_d[1]   = (rd_line < height);
    row_ok_d[2]   = ((13'(rd_line) + 13'd1) < 13'(height));
    row_ok_d[3]   = ((13'(rd_line) + 13'd2) < 13'(height));
    row_slot_d[0] = slot_add(rd_slot, 3'd4);
    row_slot_d[1] = rd_slot;
    row_slot_d[2] = slot_add(rd_slot, 3'd1);
    row_slot_d[3] = slot_add(rd_slot, 3'd2);
  end

  // Storage: 5 slots x 4 column-interleaved banks
  logic [DW-1:0] ram_q [NSLOT][TAPS];

  for (genvar s = 0; s < NSLOT; s++) begin : gen_slot
    for (genvar b = 0; b < TAPS; b++) begin : gen_bank
      line_bank_ram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
      ) u_ram (
        .clk   (clk),
        .we    (accept && (wr_slot == 3'(s)) && (wr_col[1:0] == 2'(b))),
        .waddr (wr_col[AW+1:2]),
        .wdata (data_i),
        .raddr (bank_raddr[b]),
        .rdata (ram_q[s][b])
      );
    end
  end

  // Stage 1 control aligned with RAM read data
  logic            valid_p1;
  logic [1:0]      rot_q;
  logic [TAPS-1:0] col_ok_q;
  logic [TAPS-1:0] row_ok_q;
  slot_t           row_slot_q [TAPS];

  // Read-valid pipe; squashed by reset
  always_ff @(posedge clk) begin
    if (reset) valid_p1 <= 1'b0;
    else       valid_p1 <= rd_en & rd_ready;
  end

  // Mux selects travel alongside the RAM access
  always_ff @(posedge clk) begin
    rot_q    <= rot_d;
    col_ok_q <= col_ok_d;
    row_ok_q <= row_ok_d;
    for (int r = 0; r < TAPS; r++) row_slot_q[r] <= row_slot_d[r];
  end

  // Stage 1: slot-to-row mux, lane rotation back to column order, zero out-of-frame taps
  window_t win [TAPS];

  always_comb begin
    for (int r = 0; r < TAPS; r++) begin
      win[r] = '0;
      for (int k = 0; k < TAPS; k++) begin
        if (row_ok_q[r] && col_ok_q[k])
          win[r][(TAPS-1-k)*DW +: DW] = ram_q[row_slot_q[r]][2'(rot_q + 2'(k))];
      end
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_o           <= 1'b0;
      prev_line_data_o  <= '0;
      cur_line_data_o   <= '0;
      next_line1_data_o <= '0;
      next_line2_data_o <= '0;
    end else begin
      valid_o <= valid_p1;
      if (valid_p1) begin
        prev_line_data_o  <= win[0];
        cur_line_data_o   <= win[1];
        next_line1_data_o <= win[2];
        next_line2_data_o <= win[3];
      end
    end
  end

endmodule
